// File: rtl/slot_onehot_alloc.sv
// slot_onehot_alloc: busy-bitmap slot allocator for 2^IDX_W tags.
// Grants the lowest free index (binary + one-hot) one cycle after an accepted
// request and frees slots through a decoded one-hot release mask.
// Optional feature macro: SLOT_ALLOC_ERR_EN adds the rel_err pulse output,
// flagging releases of slots that are not currently busy.
module slot_onehot_alloc #(
  parameter int IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   alloc_req,
  output logic                   alloc_rdy,
  output logic                   alloc_vld,
  output logic [IDX_W-1:0]       alloc_idx,
  output logic [(1<<IDX_W)-1:0]  alloc_oh,
  input  logic                   rel_vld,
  input  logic [IDX_W-1:0]       rel_idx,
  output logic [(1<<IDX_W)-1:0]  busy,
  output logic [IDX_W:0]         free_cnt,
`ifdef SLOT_ALLOC_ERR_EN
  output logic                   rel_err,
`endif
  output logic                   full,
  output logic                   empty
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] r_busy;
  logic [IDX_W:0]   r_free_cnt;
  logic             r_alloc_vld;
  logic [IDX_W-1:0] r_alloc_idx;
  logic [DEPTH-1:0] r_alloc_oh;

  logic [IDX_W-1:0] w_grant;
  logic [DEPTH-1:0] w_grant_oh;
  logic [DEPTH-1:0] w_rel_oh;
  logic             w_alloc_eff;
  logic             w_rel_eff;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [IDX_W:0]   w_cnt_nxt;

  // Lowest free index of the pre-edge bitmap; scanning downward lets the
  // lowest zero win. A slot released this cycle is still busy here, so it
  // cannot be re-granted in the same cycle.
  always_comb begin
    w_grant = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_grant = IDX_W'(i);
      end
    end
  end

  // Ready/full/empty depend only on registered state.
  assign alloc_rdy   = ~&r_busy;
  assign full        = (r_free_cnt == '0);
  assign empty       = (r_free_cnt == (IDX_W+1)'(DEPTH));

  assign w_alloc_eff = alloc_req & alloc_rdy & ~flush;
  assign w_rel_eff   = rel_vld & r_busy[rel_idx] & ~flush;

  // Set/clear masks; grant and release can never target the same slot since
  // one requires busy=0 and the other busy=1.
  assign w_grant_oh  = DEPTH'(1) << w_grant;
  assign w_rel_oh    = w_rel_eff ? (DEPTH'(1) << rel_idx) : '0;
  assign w_busy_nxt  = (r_busy & ~w_rel_oh) | (w_alloc_eff ? w_grant_oh : '0);
  assign w_cnt_nxt   = r_free_cnt + (IDX_W+1)'(w_rel_eff) - (IDX_W+1)'(w_alloc_eff);

  // Bitmap, free counter and grant result registers; flush wipes allocations
  // but leaves the last grant index/mask in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= '0;
      r_free_cnt  <= (IDX_W+1)'(DEPTH);
      r_alloc_vld <= 1'b0;
      r_alloc_idx <= '0;
      r_alloc_oh  <= '0;
    end else if (flush) begin
      r_busy      <= '0;
      r_free_cnt  <= (IDX_W+1)'(DEPTH);
      r_alloc_vld <= 1'b0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_free_cnt  <= w_cnt_nxt;
      r_alloc_vld <= w_alloc_eff;
      if (w_alloc_eff) begin
        r_alloc_idx <= w_grant;
        r_alloc_oh  <= w_grant_oh;
      end
    end
  end

`ifdef SLOT_ALLOC_ERR_EN
  logic r_rel_err;

  // One-cycle pulse for a release of a slot that is not busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rel_err <= 1'b0;
    end else begin
      r_rel_err <= rel_vld & ~flush & ~r_busy[rel_idx];
    end
  end

  assign rel_err = r_rel_err;
`endif

  assign busy      = r_busy;
  assign free_cnt  = r_free_cnt;
  assign alloc_vld = r_alloc_vld;
  assign alloc_idx = r_alloc_idx;
  assign alloc_oh  = r_alloc_oh;

endmodule

// File: tb/tb_slot_onehot_alloc.sv
// Self-checking bench for slot_onehot_alloc (IDX_W=4) with a grant scoreboard.
module tb_slot_onehot_alloc;

  localparam int IDX_W = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             alloc_req;
  logic             alloc_rdy;
  logic             alloc_vld;
  logic [IDX_W-1:0] alloc_idx;
  logic [DEPTH-1:0] alloc_oh;
  logic             rel_vld;
  logic [IDX_W-1:0] rel_idx;
  logic [DEPTH-1:0] busy;
  logic [IDX_W:0]   free_cnt;
  logic             full;
  logic             empty;
`ifdef SLOT_ALLOC_ERR_EN
  logic             rel_err;
`endif

  slot_onehot_alloc #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .alloc_req (alloc_req),
    .alloc_rdy (alloc_rdy),
    .alloc_vld (alloc_vld),
    .alloc_idx (alloc_idx),
    .alloc_oh  (alloc_oh),
    .rel_vld   (rel_vld),
    .rel_idx   (rel_idx),
    .busy      (busy),
    .free_cnt  (free_cnt),
`ifdef SLOT_ALLOC_ERR_EN
    .rel_err   (rel_err),
`endif
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [DEPTH-1:0] m_busy;
  int               m_cnt;
  logic             exp_vld;
  logic             exp_err;
  logic [IDX_W-1:0] last_idx;
  logic [DEPTH-1:0] last_oh;
  logic [IDX_W-1:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [IDX_W-1:0] lowest_free(input logic [DEPTH-1:0] b);
    for (int i = 0; i < DEPTH; i++) begin
      if (!b[i]) return IDX_W'(i);
    end
    return '0;
  endfunction

  // Apply current inputs for one clock, advance the model, then check outputs.
  task automatic step();
    logic             acc;
    logic             rel_e;
    logic [IDX_W-1:0] g;
    logic [IDX_W-1:0] popped;
    g = lowest_free(m_busy);
    if (rst) begin
      m_busy = '0; m_cnt = DEPTH; exp_vld = 0; exp_err = 0;
      last_idx = '0; last_oh = '0;
      sb_q.delete();
    end else if (flush) begin
      m_busy = '0; m_cnt = DEPTH; exp_vld = 0; exp_err = 0;
    end else begin
      acc     = alloc_req && (m_busy != '1);
      rel_e   = rel_vld && m_busy[rel_idx];
      exp_err = rel_vld && !m_busy[rel_idx];
      if (acc) begin
        sb_q.push_back(g);
        m_busy[g] = 1'b1;
      end
      if (rel_e) m_busy[rel_idx] = 1'b0;
      m_cnt   = m_cnt + int'(rel_e) - int'(acc);
      exp_vld = acc;
    end
    @(posedge clk);
    #1;
    check_eq("alloc_vld", alloc_vld, exp_vld);
    if (alloc_vld) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 0, 1);
      end else begin
        popped   = sb_q.pop_front();
        last_idx = popped;
        last_oh  = DEPTH'(1) << popped;
      end
    end
    check_eq("alloc_idx", alloc_idx, last_idx);
    check_eq("alloc_oh", alloc_oh, last_oh);
    check_eq("busy", busy, m_busy);
    check_eq("free_cnt", free_cnt, m_cnt);
    check_eq("alloc_rdy", alloc_rdy, m_busy != '1);
    check_eq("full", full, m_cnt == 0);
    check_eq("empty", empty, m_cnt == DEPTH);
`ifdef SLOT_ALLOC_ERR_EN
    check_eq("rel_err", rel_err, exp_err);
`endif
  endtask

  task automatic idle();
    rst = 0; flush = 0; alloc_req = 0; rel_vld = 0; rel_idx = '0;
  endtask

  task automatic release_slot(input int idx);
    idle(); rel_vld = 1; rel_idx = IDX_W'(idx); step(); idle();
  endtask

  task automatic fill_all();
    idle(); flush = 1; step(); idle();
    alloc_req = 1;
    for (int i = 0; i < DEPTH; i++) step();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_busy = '0; m_cnt = DEPTH; exp_vld = 0; exp_err = 0;
    last_idx = '0; last_oh = '0;
    idle();
    rst = 1;
    step(); step();
    idle();
    // Reset values, including derived outputs
    check_eq("rst_busy", busy, 16'h0000);
    check_eq("rst_free", free_cnt, 16);
    check_eq("rst_idx", alloc_idx, 0);
    check_eq("rst_oh", alloc_oh, 16'h0000);
    check_eq("rst_rdy", alloc_rdy, 1);
    check_eq("rst_empty", empty, 1);

    // 16 back-to-back grants in order
    alloc_req = 1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check_eq("seq_idx", alloc_idx, i);
      check_eq("seq_oh", alloc_oh, 16'(1) << i);
    end
    check_eq("full_after16", full, 1);
    check_eq("rdy_when_full", alloc_rdy, 0);
    step();
    check_eq("req17_vld", alloc_vld, 0);

    // Full: release 9 together with a request
    idle(); alloc_req = 1; rel_vld = 1; rel_idx = 4'd9;
    step();
    check_eq("relalloc_vld", alloc_vld, 0);
    check_eq("relalloc_free", free_cnt, 1);
    check_eq("relalloc_rdy", alloc_rdy, 1);
    idle(); alloc_req = 1;
    step();
    check_eq("regrant9", alloc_idx, 9);
    check_eq("regrant9_free", free_cnt, 0);
    idle();

    // busy=0x00FF then simultaneous release 3 + alloc
    idle(); flush = 1; step(); idle();
    alloc_req = 1;
    for (int i = 0; i < 8; i++) step();
    check_eq("pre_00ff", busy, 16'h00FF);
    idle(); alloc_req = 1; rel_vld = 1; rel_idx = 4'd3;
    step();
    check_eq("swap_idx", alloc_idx, 8);
    check_eq("swap_busy", busy, 16'h01F7);
    check_eq("swap_free", free_cnt, 8);
    idle();

    // Invalid release of slot 5
    release_slot(5);
    check_eq("rel5_busy", busy, 16'h01D7);
    release_slot(5);
    check_eq("dblfree_busy", busy, 16'h01D7);
    check_eq("dblfree_free", free_cnt, 9);
`ifdef SLOT_ALLOC_ERR_EN
    check_eq("dblfree_err", rel_err, 1);
    step();
    check_eq("dblfree_err_pulse", rel_err, 0);
`endif

    // Flush with alloc and release at 0xA5A5
    fill_all();
    release_slot(1);  release_slot(3);  release_slot(4);  release_slot(6);
    release_slot(9);  release_slot(11); release_slot(12); release_slot(14);
    check_eq("pre_a5a5", busy, 16'hA5A5);
    idle(); flush = 1; alloc_req = 1; rel_vld = 1; rel_idx = 4'd0;
    step();
    check_eq("flush_busy", busy, 16'h0000);
    check_eq("flush_free", free_cnt, 16);
    check_eq("flush_vld", alloc_vld, 0);
    check_eq("flush_empty", empty, 1);
    idle();

    // Reset mid-stream at 0x0F0F
    fill_all();
    for (int i = 4; i < 8; i++) release_slot(i);
    for (int i = 12; i < 16; i++) release_slot(i);
    check_eq("pre_0f0f", busy, 16'h0F0F);
    idle(); rst = 1; alloc_req = 1; rel_vld = 1; rel_idx = 4'd0;
    step();
    check_eq("midrst_busy", busy, 16'h0000);
    check_eq("midrst_free", free_cnt, 16);
    check_eq("midrst_vld", alloc_vld, 0);
    check_eq("midrst_oh", alloc_oh, 16'h0000);
    idle(); alloc_req = 1;
    step();
    check_eq("post_rst_grant", alloc_idx, 0);
    idle();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst       = 0;
      flush     = ($urandom_range(0, 39) == 0);
      alloc_req = ($urandom_range(0, 2) != 0);
      rel_vld   = ($urandom_range(0, 1) != 0);
      rel_idx   = IDX_W'($urandom_range(0, DEPTH - 1));
      step();
    end
    idle();
    step();
    check_eq("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
